// File: rtl/clk_en_div_if.sv
// Divide-ratio change handshake (four-phase req/ack) for clk_en_div.
// master drives DIV_REQ/DIV_VAL and sees DIV_ACK; slave is the divider.
interface clk_en_div_if #(
    parameter int CNT_W = 8
);
    logic             DIV_REQ;
    logic [CNT_W-1:0] DIV_VAL;
    logic             DIV_ACK;

    modport master (
        output DIV_REQ,
        output DIV_VAL,
        input  DIV_ACK
    );

    modport slave (
        input  DIV_REQ,
        input  DIV_VAL,
        output DIV_ACK
    );
endinterface

// File: rtl/clk_en_div.sv
// Programmable clock-enable divider: CLK_EN strobe every DIV cycles,
// PHASE toggling reference, run-time ratio change via div_if req/ack.
// Ports: CLK_IN, RESETN (async low), EN, div_if (slave), CLK_EN,
// PHASE, DIV_CUR, SYNC_RST_N.
// Macro CLK_EN_DIV_RST_STRETCH_EN: hold SYNC_RST_N low until
// 4 CLK_EN pulses have been issued after synchronizer release.
module clk_en_div #(
    parameter int CNT_W   = 8,
    parameter int RST_DIV = 2
) (
    input  logic             CLK_IN,
    input  logic             RESETN,
    input  logic             EN,
    clk_en_div_if.slave      div_if,
    output logic             CLK_EN,
    output logic             PHASE,
    output logic [CNT_W-1:0] DIV_CUR,
    output logic             SYNC_RST_N
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PEND
    } state_t;

    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] RDIV = CNT_W'(RST_DIV);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] nxt_q, nxt_d;
    logic             clk_en_q, clk_en_d;
    logic             phase_q, phase_d;
    logic             ack_q, ack_d;
    logic             accept;
    logic             wrap;
    logic [CNT_W-1:0] val_eff;
    logic [1:0]       sync_q;

    // A ratio of 0 is meaningless; treat it as 1 (continuous enable).
    assign val_eff = (div_if.DIV_VAL == '0) ? ONE : div_if.DIV_VAL;
    assign accept  = div_if.DIV_REQ && !ack_q && (state_q != PEND);
    assign wrap    = (cnt_q == div_q - ONE);

    always_ff @(posedge CLK_IN or negedge RESETN) begin
        if (!RESETN) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            div_q    <= RDIV;
            nxt_q    <= RDIV;
            clk_en_q <= 1'b0;
            phase_q  <= 1'b0;
            ack_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            div_q    <= div_d;
            nxt_q    <= nxt_d;
            clk_en_q <= clk_en_d;
            phase_q  <= phase_d;
            ack_q    <= ack_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        div_d    = div_q;
        nxt_d    = nxt_q;
        clk_en_d = 1'b0;
        phase_d  = phase_q;
        // Ack is held until the requester is seen releasing DIV_REQ.
        ack_d    = ack_q & div_if.DIV_REQ;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (accept) begin
                    div_d = val_eff;
                    ack_d = 1'b1;
                end
                if (EN) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!EN) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    if (wrap) begin
                        cnt_d    = '0;
                        clk_en_d = 1'b1;
                        phase_d  = ~phase_q;
                    end else begin
                        cnt_d = cnt_q + ONE;
                    end
                    if (accept) begin
                        nxt_d   = val_eff;
                        state_d = PEND;
                    end
                end
            end
            PEND: begin
                // Stopping flushes the pending ratio so the requester
                // is never left waiting on a divider that is frozen.
                if (!EN) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    div_d   = nxt_q;
                    ack_d   = 1'b1;
                end else if (wrap) begin
                    cnt_d    = '0;
                    clk_en_d = 1'b1;
                    phase_d  = ~phase_q;
                    div_d    = nxt_q;
                    ack_d    = 1'b1;
                    state_d  = RUN;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK_IN or negedge RESETN) begin
        if (!RESETN) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], 1'b1};
        end
    end

`ifdef CLK_EN_DIV_RST_STRETCH_EN
    logic [2:0] pulse_q;

    // Count strobes only once the synchronizer has released.
    always_ff @(posedge CLK_IN or negedge RESETN) begin
        if (!RESETN) begin
            pulse_q <= 3'd0;
        end else if (sync_q[1] && clk_en_q && (pulse_q != 3'd4)) begin
            pulse_q <= pulse_q + 3'd1;
        end
    end

    assign SYNC_RST_N = sync_q[1] && (pulse_q == 3'd4);
`else
    assign SYNC_RST_N = sync_q[1];
`endif

    assign CLK_EN         = clk_en_q;
    assign PHASE          = phase_q;
    assign DIV_CUR        = div_q;
    assign div_if.DIV_ACK = ack_q;

endmodule

// File: doc/clk_en_div.md
# clk_en_div

Programmable clock-enable divider for the Dilithium fabric clock tree. It runs on the fabric clock and produces a one-cycle `CLK_EN` strobe every `DIV` cycles, plus a toggling `PHASE` reference. It also produces a stretched synchronous reset for logic gated by that strobe. It sits directly downstream of the fixed fabric clock divider and lets the NTT/Keccak datapath run at run-time-selectable rates without a second PLL/clock-divider output. The divide ratio is changed through a four-phase request/acknowledge handshake and takes effect only on a period boundary.

## Interface
- `CNT_W`, default 8: width of the divide ratio and the internal counter.
- `RST_DIV`, default 2: divide ratio loaded at reset. Range 1..2^CNT_W-1.
- `CLK_IN` (input, 1): fabric clock, the only clock. All logic is on its rising edge.
- `RESETN` (input, 1): reset, asynchronous, active-low.
- `EN` (input, 1): run enable. Low freezes the divider in IDLE.
- `DIV_REQ` (input, 1): divide-ratio change request, four-phase.
- `DIV_VAL` (input, CNT_W): requested ratio. Sampled in the cycle the request is accepted.
- `DIV_ACK` (output, 1): acknowledge. High from the cycle the new ratio is in effect until `DIV_REQ` is seen low.
- `CLK_EN` (output, 1): registered enable strobe.
- `PHASE` (output, 1): toggles on every `CLK_EN` pulse, giving a divide-by-2·DIV level.
- `DIV_CUR` (output, CNT_W): ratio currently in effect.
- `SYNC_RST_N` (output, 1): active-low reset for strobe-gated logic. Asserts asynchronously and deasserts synchronously.

## Operation
- Registers: counter `cnt` (CNT_W), `div_q` (driven on `DIV_CUR`), `div_nxt` (pending ratio), and a state machine with states IDLE, RUN and PEND.
- Effective ratio: `DIV_VAL` of 0 is stored as 1. A ratio of 1 means `CLK_EN` stays high continuously while running.
- IDLE:
  - `cnt` = 0 and `CLK_EN` = 0.
  - Goes to RUN when `EN` = 1.
  - An accepted request loads `div_q` directly and raises `DIV_ACK` on the next cycle.
- RUN:
  - `cnt` counts 0..div_q-1 and wraps.
  - `CLK_EN` is registered high in the cycle after `cnt` reaches div_q-1, for exactly one cycle per period.
  - An accepted request stores `DIV_VAL` into `div_nxt` and moves to PEND.
- PEND:
  - Counting continues with the old ratio.
  - In the cycle `cnt` wraps to 0, `div_q` ← `div_nxt` and `DIV_ACK` rises, then the state returns to RUN.
  - The first period after the switch uses the new ratio.
- Request acceptance: `DIV_REQ` = 1, `DIV_ACK` = 0, and the state is not PEND. `DIV_REQ` activity during PEND or while `DIV_ACK` is high is ignored.
- `DIV_ACK` falls in the cycle after `DIV_REQ` is sampled low. A new request needs `DIV_REQ` low for at least one cycle first.
- `EN` falls in RUN or PEND:
  - Next cycle: IDLE, `cnt` = 0, `CLK_EN` = 0, `PHASE` holds its value.
  - A pending ratio is applied immediately and acknowledged.
- `EN` and the wrap happen in the same cycle: `EN` wins, and no `CLK_EN` pulse is issued.
- Mid-operation reset: all state returns to reset values immediately, and any pending request is discarded.

## Timing
- Reset values:
  - `CLK_EN` = 0, `PHASE` = 0, `DIV_ACK` = 0, `SYNC_RST_N` = 0.
  - `DIV_CUR` = RST_DIV, `cnt` = 0, state IDLE.
- `EN` is first sampled high at edge k: the first `CLK_EN` is high in the cycle after edge k+DIV. Subsequent pulses are exactly DIV cycles apart.
- Ratio change in RUN: `DIV_ACK` rises in the cycle `DIV_CUR` shows the new value, which is at most old-DIV cycles after acceptance.
- Ratio change in IDLE: `DIV_ACK` and `DIV_CUR` update one cycle after acceptance.
- `SYNC_RST_N` (no macro): 2-flop synchronizer of `RESETN`. It deasserts 2 cycles after `RESETN` rises.

## Configuration
- `CLK_EN_DIV_RST_STRETCH_EN` defined:
  - After the synchronizer releases, `SYNC_RST_N` stays low until 4 `CLK_EN` pulses have been issued.
  - It goes high in the cycle after the 4th pulse.
  - While `EN` = 0, it stays low indefinitely.
- Macro not defined: plain 2-flop synchronizer only, with no stretch counter.

## Test plan
- Reset, hold `EN` = 0 for 10 cycles: `CLK_EN` = 0, `DIV_CUR` = 2, `DIV_ACK` = 0, `PHASE` = 0 throughout.
- `EN` = 1 with RST_DIV = 2 over 20 cycles: 10 single-cycle `CLK_EN` pulses, the first in the cycle after edge k+2, and `PHASE` toggles 10 times.
- In RUN with DIV = 5, request `DIV_VAL` = 3 at `cnt` = 1:
  - `DIV_ACK` and `DIV_CUR` = 3 appear at the wrap, 4 cycles later.
  - The next pulse gaps are 5 then 3.
- Request `DIV_VAL` = 0: `DIV_CUR` = 1 and `CLK_EN` stays high continuously. Holding `DIV_REQ` high after ack causes no second change.
- Drop `EN` during PEND (old DIV = 4, new = 7): IDLE next cycle, `DIV_CUR` = 7, `DIV_ACK` = 1, no `CLK_EN` pulse.
- Pulse `RESETN` low for 1 cycle mid-RUN: all outputs return to reset values at once. `SYNC_RST_N` rises 2 cycles after release, or after 4 pulses with `CLK_EN_DIV_RST_STRETCH_EN`.
